// File: rtl/cpu_mc_pkg.sv
// Shared types for the multi-cycle core: opcodes, FSM states and the
// instruction-width helper.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_MOVI  = 3'd5,
    OP_BNZ   = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // 3-bit opcode followed by two register fields
  function automatic int calc_iw(input int nreg);
    return 3 + 2 * $clog2(nreg);
  endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// NREG x DW register file: two combinational read ports, one write port,
// asynchronous clear to zero.
module cpu_mc_regfile #(
  parameter  int DW   = 8,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [RW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [NREG-1:0][DW-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU: FETCH/EXEC/MEM sequencer around a register file and ALU,
// with a synchronous instruction ROM and a req/ready data memory port.
module cpu_core_mc
  import cpu_mc_pkg::*;
#(
  parameter  int DW   = 8,
  parameter  int NREG = 8,
  parameter  int PCW  = 10,
  parameter  int CTW  = 16,
  localparam int RW   = $clog2(NREG),
  localparam int IW   = calc_iw(NREG)
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  output logic           Ack,
  output logic [PCW-1:0] Imem_addr,
  input  logic [IW-1:0]  Imem_data,
  output logic           Dmem_req,
  output logic           Dmem_we,
  output logic [DW-1:0]  Dmem_addr,
  output logic [DW-1:0]  Dmem_wdata,
  input  logic [DW-1:0]  Dmem_rdata,
  input  logic           Dmem_ready,
  output logic [CTW-1:0] CycleCt
);

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CTW-1:0]  ct_q, ct_d;
  logic            z_q, z_d;
  logic            ack_q, ack_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [RW-1:0]   ra_q, ra_d;

  op_e             op;
  logic [RW-1:0]   ra, rb;
  logic [DW-1:0]   rf_a, rf_b, alu_res;
  logic [PCW-1:0]  br_off;
  logic            rf_we;
  logic [RW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;

  assign op = op_e'(Imem_data[IW-1 -: 3]);
  assign ra = Imem_data[2*RW-1 -: RW];
  assign rb = Imem_data[RW-1:0];
  // {ra,rb} is a signed word offset; the cast sign-extends or truncates to PCW
  assign br_off = PCW'(signed'(Imem_data[2*RW-1:0]));

  cpu_mc_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk     (Clk),
    .rst_n   (Reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (ra),
    .rdata_a (rf_a),
    .raddr_b (rb),
    .rdata_b (rf_b)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = rf_a + rf_b;
      OP_SUB:  alu_res = rf_a - rf_b;
      OP_AND:  alu_res = rf_a & rf_b;
      OP_MOVI: alu_res = DW'(rb);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (Start) state_d = S_FETCH;
      S_FETCH:        state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_HALT:           state_d = S_DONE;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM:          if (Dmem_ready) state_d = S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    ct_d     = ct_q;
    z_d      = z_q;
    ack_d    = ack_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ra_d     = ra_q;
    rf_we    = 1'b0;
    rf_waddr = ra;
    rf_wdata = alu_res;

    if ((state_q == S_FETCH || state_q == S_EXEC || state_q == S_MEM) && ct_q != '1)
      ct_d = ct_q + CTW'(1);

    case (state_q)
      S_IDLE: if (Start) begin
        pc_d = '0;
        ct_d = '0;
        z_d  = 1'b0;
      end
      S_DONE: if (Start) begin
        pc_d  = '0;
        ct_d  = '0;
        ack_d = 1'b0;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_MOVI: begin
            rf_we = 1'b1;
            z_d   = (alu_res == '0);
            pc_d  = pc_q + PCW'(1);
          end
          OP_BNZ:  pc_d = z_q ? pc_q + PCW'(1) : pc_q + br_off;
          OP_LOAD, OP_STORE: begin
            // operands captured here stay stable for the whole MEM wait
            req_d   = 1'b1;
            we_d    = (op == OP_STORE);
            addr_d  = rf_b;
            wdata_d = rf_a;
            ra_d    = ra;
          end
          default: ack_d = 1'b1;
        endcase
      end
      S_MEM: if (Dmem_ready) begin
        req_d = 1'b0;
        pc_d  = pc_q + PCW'(1);
        if (!we_q) begin
          rf_we    = 1'b1;
          rf_waddr = ra_q;
          rf_wdata = Dmem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q    <= '0;
      ct_q    <= '0;
      z_q     <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ra_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      ct_q    <= ct_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ra_q    <= ra_d;
    end
  end

  assign Ack        = ack_q;
  assign Imem_addr  = pc_q;
  assign Dmem_req   = req_q;
  assign Dmem_we    = we_q;
  assign Dmem_addr  = addr_q;
  assign Dmem_wdata = wdata_q;
  assign CycleCt    = ct_q;

endmodule
